// File: rtl/sys_defs_pkg.sv
// Shared machine-wide definitions: physical tag geometry, retire width and
// the tag type exchanged between the ROB, free list and release queue.
package sys_defs;

    localparam int unsigned SYS_TAG_W    = 7;
    localparam int unsigned SYS_PREG_N   = 1 << SYS_TAG_W;
    localparam int unsigned SYS_ZERO_TAG = 0;
    localparam int unsigned SYS_RET_W    = 2;
    localparam int unsigned SYS_RQ_DEPTH = 8;

    typedef logic [SYS_TAG_W-1:0] ptag_t;

endpackage

// File: rtl/told_release_queue_compact.sv
// Packs the releasable retire slots (valid and not the zero tag) into a dense,
// slot-ordered write vector and reports how many were packed.
module ret_compact
    import sys_defs::*;
#(
    parameter int unsigned TAG_W    = SYS_TAG_W,
    parameter int unsigned RET_W    = SYS_RET_W,
    parameter int unsigned ZERO_TAG = SYS_ZERO_TAG,
    localparam int unsigned NIN_W   = $clog2(RET_W + 1)
) (
    input  logic [RET_W-1:0]            valid_i,
    input  logic [RET_W-1:0][TAG_W-1:0] told_i,
    output logic [RET_W-1:0][TAG_W-1:0] tags_o,
    output logic [NIN_W-1:0]            n_in_o
);

    localparam int unsigned IDX_W = (RET_W > 1) ? $clog2(RET_W) : 1;

    logic [NIN_W-1:0] n;

    always_comb begin
        tags_o = '0;
        n      = '0;
        for (int unsigned i = 0; i < RET_W; i++) begin
            if (valid_i[i] && (told_i[i] != TAG_W'(ZERO_TAG))) begin
                tags_o[n[IDX_W-1:0]] = told_i[i];
                n = n + NIN_W'(1);
            end
        end
        n_in_o = n;
    end

endmodule

// File: rtl/told_release_queue.sv
// Buffers stale Told tags released at retirement and returns them to the
// free list one per cycle through its push/full handshake.
module told_release_queue
    import sys_defs::*;
#(
    parameter int unsigned TAG_W    = SYS_TAG_W,
    parameter int unsigned DEPTH    = SYS_RQ_DEPTH,
    parameter int unsigned RET_W    = SYS_RET_W,
    parameter int unsigned ZERO_TAG = SYS_ZERO_TAG
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [RET_W-1:0]            ret_valid,
    input  logic [RET_W-1:0][TAG_W-1:0] ret_told,
    output logic                        ret_stall,
    output logic                        fl_push,
    output logic [TAG_W-1:0]            fl_tag,
    input  logic                        fl_full,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NIN_W = $clog2(RET_W + 1);
    // Stall once fewer than RET_W free entries remain.
    localparam logic [CNT_W-1:0] STALL_ABOVE = CNT_W'(DEPTH - RET_W);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [TAG_W-1:0] mem_q [DEPTH];

    logic [RET_W-1:0][TAG_W-1:0] wr_tags;
    logic [NIN_W-1:0]            n_raw;
    logic [NIN_W-1:0]            n_in;

    ret_compact #(
        .TAG_W    (TAG_W),
        .RET_W    (RET_W),
        .ZERO_TAG (ZERO_TAG)
    ) u_compact (
        .valid_i (ret_valid),
        .told_i  (ret_told),
        .tags_o  (wr_tags),
        .n_in_o  (n_raw)
    );

    assign ret_stall    = count_q > STALL_ABOVE;
    assign empty        = count_q == '0;
    assign fl_push      = !empty && !fl_full;
    assign fl_tag       = mem_q[head_q];
    assign count        = count_q;
    assign overflow_err = ovf_q;
    assign n_in         = ret_stall ? '0 : n_raw;

    always_comb begin
        head_d  = head_q + PTR_W'(fl_push);
        tail_d  = tail_q + PTR_W'(n_in);
        count_d = count_q + CNT_W'(n_in) - CNT_W'(fl_push);
        ovf_d   = ovf_q | (ret_stall & (|ret_valid));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < RET_W; i++) begin
            if (i < 32'(n_in)) begin
                mem_q[tail_q + PTR_W'(i)] <= wr_tags[i];
            end
        end
    end

endmodule

// File: tb/tb_told_release_queue.sv
// Randomised scoreboard bench for told_release_queue against a queue-based
// reference model of the release buffer.
module tb_told_release_queue;

    logic             clk;
    logic             reset_n;
    logic [1:0]       ret_valid;
    logic [1:0][6:0]  ret_told;
    logic             ret_stall;
    logic             fl_push;
    logic [6:0]       fl_tag;
    logic             fl_full;
    logic [3:0]       count;
    logic             empty;
    logic             overflow_err;

    told_release_queue #(
        .TAG_W    (7),
        .DEPTH    (8),
        .RET_W    (2),
        .ZERO_TAG (0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ret_valid    (ret_valid),
        .ret_told     (ret_told),
        .ret_stall    (ret_stall),
        .fl_push      (fl_push),
        .fl_tag       (fl_tag),
        .fl_full      (fl_full),
        .count        (count),
        .empty        (empty),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int         model_cnt = 0;
    logic       model_ovf = 1'b0;
    logic [6:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; reference model: FIFO of accepted tags, capacity 8.
    task automatic step(input logic [1:0] v, input logic [6:0] t0,
                        input logic [6:0] t1, input logic full);
        logic stall_m;
        logic push_m;
        int   n_in;
        @(negedge clk);
        #1;
        stall_m = (8 - model_cnt) < 2;
        chk("count", int'(count), model_cnt);
        chk("empty", int'(empty), int'(model_cnt == 0));
        chk("ret_stall", int'(ret_stall), int'(stall_m));
        chk("overflow_err", int'(overflow_err), int'(model_ovf));
        ret_valid   = v;
        ret_told[0] = t0;
        ret_told[1] = t1;
        fl_full     = full;
        push_m = (model_cnt != 0) && !full;
        n_in = 0;
        if (v != 2'b00 && stall_m) begin
            model_ovf = 1'b1;
        end else begin
            if (v[0] && t0 != 7'd0) begin exp_q.push_back(t0); n_in++; end
            if (v[1] && t1 != 7'd0) begin exp_q.push_back(t1); n_in++; end
        end
        model_cnt = model_cnt + n_in - int'(push_m);
        #1;
        chk("fl_push", int'(fl_push), int'(push_m));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 7'd0, 7'd0, 1'b0);
    endtask

    // Monitor: every real push (sampled just before the edge) must match the scoreboard head.
    initial begin
        logic [6:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (reset_n && fl_push) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL fl_tag: unexpected push of %0d with nothing expected at %0t", fl_tag, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (fl_tag !== e) begin
                        n_err++;
                        $display("FAIL fl_tag: got %0d expected %0d at %0t", fl_tag, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] rv;
        logic [6:0] r0, r1;
        logic       rf;
        reset_n   = 1'b0;
        ret_valid = '0;
        ret_told  = '0;
        fl_full   = 1'b0;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_fl_push", int'(fl_push), 0);
        chk("rst_ret_stall", int'(ret_stall), 0);
        chk("rst_overflow", int'(overflow_err), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Single release, then drain
        step(2'b01, 7'd12, 7'd0, 1'b0);
        idle(2);

        // Dual retire ordering: 3,9,20,21
        step(2'b11, 7'd3, 7'd9, 1'b0);
        step(2'b11, 7'd20, 7'd21, 1'b0);
        idle(4);

        // Zero-tag filtering
        step(2'b11, 7'd0, 7'd44, 1'b0);
        step(2'b01, 7'd0, 7'd0, 1'b0);
        idle(2);

        // Backpressure to count 7, then an overflowing request
        step(2'b01, 7'd60, 7'd0, 1'b1);
        step(2'b11, 7'd61, 7'd62, 1'b1);
        step(2'b11, 7'd63, 7'd64, 1'b1);
        step(2'b11, 7'd65, 7'd66, 1'b1);
        step(2'b11, 7'd50, 7'd51, 1'b1);
        step(2'b00, 7'd0, 7'd0, 1'b1);
        idle(9);

        // Async reset mid-drain with count 5
        step(2'b01, 7'd70, 7'd0, 1'b1);
        step(2'b11, 7'd71, 7'd72, 1'b1);
        step(2'b11, 7'd73, 7'd74, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_reset_count", int'(count), model_cnt);
        ret_valid = '0;
        fl_full   = 1'b0;
        #1;
        chk("pre_reset_fl_push", int'(fl_push), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_fl_push", int'(fl_push), 0);
        chk("async_rst_overflow", int'(overflow_err), 0);
        exp_q.delete();
        model_cnt = 0;
        model_ovf = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        idle(3);

        // Randomised traffic, mostly honouring ret_stall
        for (int k = 0; k < 400; k++) begin
            rv = 2'($urandom_range(0, 3));
            r0 = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            r1 = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            rf = ($urandom_range(0, 2) == 0);
            if (((8 - model_cnt) < 2) && ($urandom_range(0, 19) != 0)) rv = 2'b00;
            step(rv, r0, r1, rf);
        end

        for (int k = 0; k < 40 && model_cnt != 0; k++) idle(1);
        idle(1);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/told_release_queue.md
Name: told_release_queue

Overview:
- Producer side of the physical-register free list. Collects stale Told tags that the ROB releases at retirement, up to RET_W per cycle.
- Buffers the tags in a small circular FIFO and feeds them back to the free list, one tag per cycle, using the free list's push/full interface.
- Sits between the ROB retire port and free_list. It decouples multi-wide retirement from the free list's single push port.

Parameters:
- TAG_W, 7, physical tag width (128 physical registers).
- DEPTH, 8, FIFO entries (power of two, at least 2*RET_W).
- RET_W, 2, retire slots per cycle.
- ZERO_TAG, 0, physical tag permanently bound to the zero register; never released.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- ret_valid, input, RET_W, per-slot release request. Slot 0 is oldest.
- ret_told, input, RET_W x TAG_W, Told tag for each slot.
- ret_stall, output, 1, high means the block cannot accept RET_W tags this cycle. The ROB must not retire while this is high.
- fl_push, output, 1, push strobe to the free list.
- fl_tag, output, TAG_W, tag being pushed.
- fl_full, input, 1, free list full; blocks the push.
- count, output, $clog2(DEPTH)+1, current FIFO occupancy.
- empty, output, 1, count==0.
- overflow_err, output, 1, sticky; set when a request arrives while ret_stall is high.

Behaviour:
- Reset (async assert, sync release):
  - head, tail and count go to 0.
  - overflow_err goes to 0.
  - Outputs after reset: fl_push=0, empty=1, ret_stall=0. fl_tag is don't-care while fl_push=0.
  - Reset mid-operation discards all buffered tags. No push is issued in the cycle reset asserts.
- Enqueue:
  - Accepted slots are those with ret_valid[i]=1 and ret_told[i]!=ZERO_TAG, provided ret_stall=0.
  - Accepted slots are written in slot order, compacted, at tail, tail+1, ... modulo DEPTH.
  - n_in = number of accepted slots (0..RET_W).
- Dequeue:
  - fl_push = !empty && !fl_full. fl_tag = mem[head]. Both are combinational from registered state only.
  - When fl_push=1, head advances by 1 modulo DEPTH at the clock edge.
- Occupancy: count_next = count + n_in - fl_push. Simultaneous enqueue and dequeue are legal in the same cycle.
- No bypass: minimum latency from a ret_valid edge to the matching fl_push is 1 cycle.
- Ordering: tags leave in exactly the order accepted (slot 0 before slot 1, older cycles first).
- ret_stall:
  - ret_stall = (DEPTH - count) < RET_W, computed from registered count only.
  - It ignores a same-cycle dequeue, so it is conservative and free of combinational loops.
- Overflow: if any ret_valid is set while ret_stall=1, all slots that cycle are dropped and overflow_err sets. overflow_err clears only on reset.
- Wrap-around: head and tail are log2(DEPTH)-bit pointers that wrap naturally. Full versus empty is resolved by count, not by pointer compare.
- fl_full held high: the FIFO fills, then ret_stall rises. There is no data loss while the ROB honours ret_stall.
- ZERO_TAG filtering is per slot.
  - Example: valid={1,1}, told={ZERO_TAG,5} enqueues only 5, and n_in=1.

Decomposition:
- Shared package (sys_defs): TAG_W and the physical register count, ZERO_TAG, RET_W.
- Also in the package: a tag typedef shared with free_list and the ROB.
- Optional sub-module: ret_compact, a combinational compaction of valid slots into a dense write vector plus n_in.
- The FIFO storage stays inline.

Test Plan:
- Reset, then single release: ret_valid=01, told[0]=12. Next cycle fl_push=1 and fl_tag=12. The cycle after, empty=1 and count=0.
- Dual retire with order check: cycle 0 valid=11, told={3,9}. Cycle 1 valid=11, told={20,21}. fl_tag sequence is 3,9,20,21 on four consecutive cycles, and count peaks at 3.
- Zero filter: valid=11, told={0,44} gives a single push of 44. valid=01, told[0]=0 gives no push, and count stays 0.
- Backpressure and wrap: hold fl_full=1 and retire 2/cycle. count reaches 7, then ret_stall=1. Release fl_full: 7 pushes in order, with head wrapping past entry 7 to entry 0 with correct data.
- Overflow: with fl_full=1, DEPTH=8, count=7 (ret_stall=1), drive valid=11 told={50,51}. Then overflow_err=1, count=7, and 50 and 51 are never pushed.
- Async reset mid-drain: assert reset_n=0 between clock edges with count=5. Outputs go immediately to count=0, empty=1, fl_push=0. After release, no stale tags appear.
